// File: rtl/median3x3_stream.sv
`timescale 1ns/1ps
// median3x3_stream: streaming 3x3 median/min/max/bypass filter using two line buffers.
// Define MEDIAN3X3_PIPE_EN to split the compute into two register stages (latency 3 instead of 2).
module median3x3_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic              adv;
  logic              accept;
  logic              win_done;
  logic              at_end;
  logic [CW-1:0]     col_reg;
  logic [RW-1:0]     row_reg;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] win_reg [9];
  logic              pend_reg;
  logic              pend_last_reg;
  logic [1:0]        pend_mode_reg;

  logic [DATA_W-1:0] s1 [9];
  logic [DATA_W-1:0] st_sort [9];
  logic [DATA_W-1:0] st_centre;
  logic              st_valid;
  logic              st_last;
  logic [1:0]        st_mode;
  logic [DATA_W-1:0] m [9];
  logic [DATA_W-1:0] mn;
  logic [DATA_W-1:0] mx;
  logic [DATA_W-1:0] result;

  function automatic logic [2*DATA_W-1:0] sort2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? {b, a} : {a, b};
  endfunction

  // One global advance enable: nothing moves while an output is stalled.
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;
  assign accept   = in_valid && adv;
  assign win_done = (row_reg >= RW'(2)) && (col_reg >= CW'(2));
  assign at_end   = (row_reg == ROW_MAX) && (col_reg == COL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (accept) begin
      if (col_reg == COL_MAX) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_MAX) ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col_reg] <= lb1[col_reg];
      lb1[col_reg] <= in_data;
    end
  end

  // Window rows: [0..2] = row r-2, [3..5] = row r-1, [6..8] = incoming row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) win_reg[i] <= '0;
    end else if (accept) begin
      win_reg[0] <= win_reg[1];
      win_reg[1] <= win_reg[2];
      win_reg[2] <= lb0[col_reg];
      win_reg[3] <= win_reg[4];
      win_reg[4] <= win_reg[5];
      win_reg[5] <= lb1[col_reg];
      win_reg[6] <= win_reg[7];
      win_reg[7] <= win_reg[8];
      win_reg[8] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg      <= 1'b0;
      pend_last_reg <= 1'b0;
      pend_mode_reg <= 2'd0;
    end else if (adv) begin
      pend_reg      <= in_valid && win_done;
      pend_last_reg <= in_valid && at_end;
      if (accept) pend_mode_reg <= mode;
    end
  end

  // First three comparator layers sort each window row; row minima land in 0/3/6, maxima in 2/5/8.
  always_comb begin
    for (int i = 0; i < 9; i++) s1[i] = win_reg[i];
    {s1[1], s1[2]} = sort2(s1[1], s1[2]);
    {s1[4], s1[5]} = sort2(s1[4], s1[5]);
    {s1[7], s1[8]} = sort2(s1[7], s1[8]);
    {s1[0], s1[1]} = sort2(s1[0], s1[1]);
    {s1[3], s1[4]} = sort2(s1[3], s1[4]);
    {s1[6], s1[7]} = sort2(s1[6], s1[7]);
    {s1[1], s1[2]} = sort2(s1[1], s1[2]);
    {s1[4], s1[5]} = sort2(s1[4], s1[5]);
    {s1[7], s1[8]} = sort2(s1[7], s1[8]);
  end

`ifdef MEDIAN3X3_PIPE_EN
  logic [DATA_W-1:0] s1_sort_reg [9];
  logic [DATA_W-1:0] s1_centre_reg;
  logic              s1_valid_reg;
  logic              s1_last_reg;
  logic [1:0]        s1_mode_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) s1_sort_reg[i] <= '0;
      s1_centre_reg <= '0;
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_mode_reg   <= 2'd0;
    end else if (adv) begin
      s1_valid_reg <= pend_reg;
      s1_last_reg  <= pend_reg && pend_last_reg;
      if (pend_reg) begin
        for (int i = 0; i < 9; i++) s1_sort_reg[i] <= s1[i];
        s1_centre_reg <= win_reg[4];
        s1_mode_reg   <= pend_mode_reg;
      end
    end
  end

  assign st_sort   = s1_sort_reg;
  assign st_centre = s1_centre_reg;
  assign st_valid  = s1_valid_reg;
  assign st_last   = s1_last_reg;
  assign st_mode   = s1_mode_reg;
`else
  assign st_sort   = s1;
  assign st_centre = win_reg[4];
  assign st_valid  = pend_reg;
  assign st_last   = pend_last_reg;
  assign st_mode   = pend_mode_reg;
`endif

  always_comb begin
    for (int i = 0; i < 9; i++) m[i] = st_sort[i];
    {m[0], m[3]} = sort2(m[0], m[3]);
    {m[5], m[8]} = sort2(m[5], m[8]);
    {m[4], m[7]} = sort2(m[4], m[7]);
    {m[3], m[6]} = sort2(m[3], m[6]);
    {m[1], m[4]} = sort2(m[1], m[4]);
    {m[2], m[5]} = sort2(m[2], m[5]);
    {m[4], m[7]} = sort2(m[4], m[7]);
    {m[4], m[2]} = sort2(m[4], m[2]);
    {m[6], m[4]} = sort2(m[6], m[4]);
    {m[4], m[2]} = sort2(m[4], m[2]);
    mn = (st_sort[0] < st_sort[3]) ? st_sort[0] : st_sort[3];
    if (st_sort[6] < mn) mn = st_sort[6];
    mx = (st_sort[2] > st_sort[5]) ? st_sort[2] : st_sort[5];
    if (st_sort[8] > mx) mx = st_sort[8];
    case (st_mode)
      2'd0:    result = m[4];
      2'd1:    result = mn;
      2'd2:    result = mx;
      default: result = st_centre;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (adv) begin
        out_valid <= st_valid;
        out_last  <= st_valid && st_last;
        if (st_valid) out_data <= result;
      end
    end
  end

endmodule

// File: tb/tb_median3x3_stream.sv
`timescale 1ns/1ps
// tb_median3x3_stream: directed table of 5x5 frames, latency/reset sequence and two random back-to-back frames.
module tb_median3x3_stream;
  localparam int W = 5;
  localparam int H = 5;
`ifdef MEDIAN3X3_PIPE_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_done;

  median3x3_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_done(frame_done)
  );

  typedef struct packed {
    int              pat;
    int              md;
    int              rdy;
    logic [8:0][7:0] exp;
  } vec_t;

  int         n_checks = 0;
  int         n_fail = 0;
  int         ready_mode = 0;
  int         ph = 0;
  int         fd_count = 0;
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic       stall_prev = 1'b0;
  logic       fd_expect = 1'b0;
  logic [7:0] held_d;
  logic       held_l;
  logic [7:0] rnd [50];
  vec_t       vecs [10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // out_ready pattern: 0 = always 1, 1 = repeating 1,0,0,1, 2 = always 0
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          out_ready = (ph == 0) || (ph == 3);
          ph = (ph + 1) % 4;
        end
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge rst_n) begin
    stall_prev = 1'b0;
    fd_expect  = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done || fd_expect) check("frame_done_timing", int'(frame_done), int'(fd_expect));
      if (frame_done) fd_count++;
      if (stall_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(held_d));
        check("hold_last", int'(out_last), int'(held_l));
      end
      if (out_valid && !out_ready) check("stall_in_ready", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        $display("out #%0d data=%0d last=%0d", got_d.size() - 1, out_data, out_last);
      end
      fd_expect  = out_valid && out_ready && out_last;
      stall_prev = out_valid && !out_ready;
      held_d     = out_data;
      held_l     = out_last;
    end
  end

  function automatic logic [8:0][7:0] e9(input int a0, input int a1, input int a2, input int a3,
                                         input int a4, input int a5, input int a6, input int a7,
                                         input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [7:0] pix(input int pat, input int idx);
    if (pat == 0) return 8'(idx);
    return (idx == 12) ? 8'hFF : 8'h40;
  endfunction

  function automatic logic [7:0] model(input int base, input int r, input int c, input int md);
    logic [7:0] v [9];
    logic [7:0] t;
    int k;
    k = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        v[k] = rnd[base + (r + dr) * W + c + dc];
        k++;
      end
    end
    if (md == 3) return v[4];
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    if (md == 1) return v[0];
    if (md == 2) return v[8];
    return v[4];
  endfunction

  task automatic drive_pix(input logic [7:0] d);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("in_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int nfd);
    for (int t = 0; t < 500; t++) begin
      if (got_d.size() >= n && fd_count >= nfd) break;
      @(posedge clk);
      #1;
    end
    repeat (6) @(posedge clk);
    #1;
    check("out_count", got_d.size(), n);
    check("frame_done_count", fd_count, nfd);
  endtask

  task automatic run_vec(input int vi);
    got_d.delete();
    got_l.delete();
    fd_count = 0;
    mode = 2'(vecs[vi].md);
    ready_mode = vecs[vi].rdy;
    for (int i = 0; i < W * H; i++) drive_pix(pix(vecs[vi].pat, i));
    wait_outputs(9, 1);
    for (int k = 0; k < 9; k++) begin
      if (k < got_d.size()) begin
        check($sformatf("v%0d_data%0d", vi, k), int'(got_d[k]), int'(vecs[vi].exp[k]));
        check($sformatf("v%0d_last%0d", vi, k), int'(got_l[k]), (k == 8) ? 1 : 0);
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    int lat;
    int idx;
    vecs[0] = '{pat: 0, md: 0, rdy: 0, exp: e9(6, 7, 8, 11, 12, 13, 16, 17, 18)};
    vecs[1] = '{pat: 0, md: 1, rdy: 0, exp: e9(0, 1, 2, 5, 6, 7, 10, 11, 12)};
    vecs[2] = '{pat: 0, md: 2, rdy: 0, exp: e9(12, 13, 14, 17, 18, 19, 22, 23, 24)};
    vecs[3] = '{pat: 0, md: 3, rdy: 0, exp: e9(6, 7, 8, 11, 12, 13, 16, 17, 18)};
    vecs[4] = '{pat: 1, md: 0, rdy: 0, exp: e9(64, 64, 64, 64, 64, 64, 64, 64, 64)};
    vecs[5] = '{pat: 1, md: 1, rdy: 0, exp: e9(64, 64, 64, 64, 64, 64, 64, 64, 64)};
    vecs[6] = '{pat: 1, md: 2, rdy: 0, exp: e9(255, 255, 255, 255, 255, 255, 255, 255, 255)};
    vecs[7] = '{pat: 1, md: 3, rdy: 0, exp: e9(64, 64, 64, 64, 255, 64, 64, 64, 64)};
    vecs[8] = '{pat: 0, md: 0, rdy: 1, exp: e9(6, 7, 8, 11, 12, 13, 16, 17, 18)};
    vecs[9] = '{pat: 1, md: 0, rdy: 1, exp: e9(64, 64, 64, 64, 64, 64, 64, 64, 64)};

    rst_n = 1'b0;
    mode = 2'd0;
    in_valid = 1'b0;
    in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_in_ready", int'(in_ready), 1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency of the first window, then an unaligned asynchronous reset while the output is stalled.
    ready_mode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) drive_pix(8'(i));
    in_valid = 1'b1;
    in_data = 8'd12;
    @(negedge clk);
    check("lat_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
    end
    check("latency", lat, EXP_LAT);
    check("first_out_data", int'(out_data), 6);
    check("stalled_in_ready", int'(in_ready), 0);
    #3 rst_n = 1'b0;
    #0.5;
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_out_data", int'(out_data), 0);
    #0.5 rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    for (int vi = 0; vi < 10; vi++) run_vec(vi);

    // Two back-to-back random frames under backpressure; mode switches at the frame boundary.
    for (int i = 0; i < 50; i++) rnd[i] = 8'($urandom_range(0, 255));
    got_d.delete();
    got_l.delete();
    fd_count = 0;
    ready_mode = 1;
    mode = 2'd0;
    for (int i = 0; i < 50; i++) begin
      if (i == 25) mode = 2'd1;
      drive_pix(rnd[i]);
    end
    wait_outputs(18, 2);
    idx = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 1; r <= H - 2; r++) begin
        for (int c = 1; c <= W - 2; c++) begin
          if (idx < got_d.size()) begin
            check($sformatf("rnd_f%0d_r%0d_c%0d", f, r, c), int'(got_d[idx]), int'(model(f * 25, r, c, f)));
            check($sformatf("rnd_last%0d", idx), int'(got_l[idx]), (idx % 9 == 8) ? 1 : 0);
          end
          idx++;
        end
      end
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
